// File: rtl/bist_pkg.sv
// Shared definitions for the scan BIST controller.
//   bist_state_e   : controller state encoding (IDLE=0 .. DONE=4)
//   DEF_*          : default polynomials, seed and golden signature
//   is_busy_state  : true for the states that make up an active run
package bist_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SHIFT   = 3'd1,
        CAPTURE = 3'd2,
        UNLOAD  = 3'd3,
        DONE    = 3'd4
    } bist_state_e;

    localparam logic [15:0] DEF_LFSR_POLY  = 16'h1021;
    localparam logic [15:0] DEF_LFSR_SEED  = 16'hACE1;
    localparam logic [15:0] DEF_MISR_POLY  = 16'h1021;
    localparam logic [15:0] DEF_GOLDEN_SIG = 16'h0000;

    function automatic logic is_busy_state(input bist_state_e s);
        return (s == SHIFT) || (s == CAPTURE) || (s == UNLOAD);
    endfunction

endpackage

// File: rtl/bist_lfsr_misr.sv
// Galois shift register usable as a stimulus LFSR (par_in tied to 0)
// or as a MISR (par_in carries the compacted response).
// Ports:
//   clock, reset : clock and synchronous active-high reset (value <= RST_VAL)
//   load         : load load_val (has priority over step)
//   load_val     : value loaded when load=1
//   step         : advance one Galois step, XOR-ing in par_in
//   par_in       : parallel input folded in on each step
//   value        : current register contents
module bist_lfsr_misr #(
    parameter int           W       = 16,
    parameter logic [W-1:0] POLY    = '0,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         step,
    input  logic [W-1:0] par_in,
    output logic [W-1:0] value
);

    logic [W-1:0] value_reg;
    logic [W-1:0] value_next;
    logic [W-1:0] stepped;

    // Shift left by one; when the MSB falls out, XOR the feedback mask in.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_bit
            if (gi == 0) begin : g_lsb
                assign stepped[gi] = value_reg[W-1] & POLY[gi];
            end else begin : g_upper
                assign stepped[gi] = value_reg[gi-1] ^ (value_reg[W-1] & POLY[gi]);
            end
        end
    endgenerate

    always_comb begin
        value_next = value_reg;
        if (load) begin
            value_next = load_val;
        end else if (step) begin
            value_next = stepped ^ par_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            value_reg <= RST_VAL;
        end else begin
            value_reg <= value_next;
        end
    end

    assign value = value_reg;

endmodule

// File: rtl/bist_scan_ctrl.sv
// Autonomous scan BIST controller. An LFSR feeds N_CHAINS scan chains
// for N_PATTERNS shift/capture rounds, chain responses are compacted in
// a MISR, and a final unload flushes the last captured response.
// Ports:
//   clock, reset : single clock, synchronous active-high reset
//   start        : begin a run (honoured in IDLE or DONE only)
//   abort        : return to IDLE, LFSR/MISR hold; wins over start
//   scan_out     : chain outputs from the CUT
//   scan_in      : chain inputs to the CUT
//   scan_en      : 1 = shift, 0 = capture
//   busy         : run in progress
//   done         : run complete, held until start/abort/reset
//   pass         : signature matches GOLDEN_SIG (only while done)
//   signature    : current MISR contents
module bist_scan_ctrl
    import bist_pkg::*;
#(
    parameter int                N_CHAINS   = 2,
    parameter int                CHAIN_LEN  = 8,
    parameter int                N_PATTERNS = 16,
    parameter int                LFSR_W     = 16,
    parameter logic [LFSR_W-1:0] LFSR_POLY  = DEF_LFSR_POLY,
    parameter logic [LFSR_W-1:0] LFSR_SEED  = DEF_LFSR_SEED,
    parameter int                MISR_W     = 16,
    parameter logic [MISR_W-1:0] MISR_POLY  = DEF_MISR_POLY,
    parameter logic [MISR_W-1:0] GOLDEN_SIG = DEF_GOLDEN_SIG
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                abort,
    input  logic [N_CHAINS-1:0] scan_out,
    output logic [N_CHAINS-1:0] scan_in,
    output logic                scan_en,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [MISR_W-1:0]   signature
);

    localparam int SC_W = $clog2(CHAIN_LEN + 1);
    localparam int PC_W = $clog2(N_PATTERNS + 1);
    localparam logic [SC_W-1:0] SHIFT_LAST = SC_W'(CHAIN_LEN - 1);
    localparam logic [PC_W-1:0] PAT_TOTAL  = PC_W'(N_PATTERNS);

    bist_state_e       state_reg, state_next;
    logic [SC_W-1:0]   shift_cnt_reg, shift_cnt_next;
    logic [PC_W-1:0]   pat_cnt_reg, pat_cnt_next;
    logic [PC_W-1:0]   pat_cnt_inc;

    logic              run_load;
    logic              lfsr_step;
    logic              misr_step;
    logic [LFSR_W-1:0] lfsr_value;
    logic [MISR_W-1:0] misr_value;
    logic [MISR_W-1:0] misr_par_in;

    assign pat_cnt_inc = pat_cnt_reg + PC_W'(1);

    // Chain responses enter the MISR zero-extended to its width.
    generate
        for (genvar gi = 0; gi < MISR_W; gi++) begin : g_misr_in
            if (gi < N_CHAINS) begin : g_chain
                assign misr_par_in[gi] = scan_out[gi];
            end else begin : g_pad
                assign misr_par_in[gi] = 1'b0;
            end
        end
    endgenerate

    // Only the low N_CHAINS LFSR bits drive the chains.
    generate
        if (N_CHAINS < LFSR_W) begin : g_lfsr_spare
            logic lfsr_unused;
            assign lfsr_unused = ^lfsr_value[LFSR_W-1:N_CHAINS];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            shift_cnt_reg <= '0;
            pat_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            shift_cnt_reg <= shift_cnt_next;
            pat_cnt_reg   <= pat_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        shift_cnt_next = shift_cnt_reg;
        pat_cnt_next   = pat_cnt_reg;
        run_load       = 1'b0;
        lfsr_step      = 1'b0;
        misr_step      = 1'b0;
        scan_en        = 1'b0;
        scan_in        = '0;
        done           = 1'b0;
        busy           = is_busy_state(state_reg);

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next     = SHIFT;
                    run_load       = 1'b1;
                    shift_cnt_next = '0;
                    pat_cnt_next   = '0;
                end
            end
            SHIFT: begin
                scan_en   = 1'b1;
                scan_in   = lfsr_value[N_CHAINS-1:0];
                lfsr_step = 1'b1;
                // While loading the first pattern the chains still hold
                // whatever preceded the run, so that unload is discarded.
                misr_step = (pat_cnt_reg != '0);
                if (shift_cnt_reg == SHIFT_LAST) begin
                    shift_cnt_next = '0;
                    state_next     = CAPTURE;
                end else begin
                    shift_cnt_next = shift_cnt_reg + SC_W'(1);
                end
            end
            CAPTURE: begin
                pat_cnt_next = pat_cnt_inc;
                state_next   = (pat_cnt_inc == PAT_TOTAL) ? UNLOAD : SHIFT;
            end
            UNLOAD: begin
                scan_en   = 1'b1;
                misr_step = 1'b1;
                if (shift_cnt_reg == SHIFT_LAST) begin
                    shift_cnt_next = '0;
                    state_next     = DONE;
                end else begin
                    shift_cnt_next = shift_cnt_reg + SC_W'(1);
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next     = SHIFT;
                    run_load       = 1'b1;
                    shift_cnt_next = '0;
                    pat_cnt_next   = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Abort overrides everything, including a simultaneous start,
        // and freezes LFSR/MISR so the partial signature stays visible.
        if (abort) begin
            state_next     = IDLE;
            shift_cnt_next = '0;
            pat_cnt_next   = '0;
            run_load       = 1'b0;
            lfsr_step      = 1'b0;
            misr_step      = 1'b0;
        end
    end

    bist_lfsr_misr #(
        .W       (LFSR_W),
        .POLY    (LFSR_POLY),
        .RST_VAL (LFSR_SEED)
    ) u_lfsr (
        .clock    (clock),
        .reset    (reset),
        .load     (run_load),
        .load_val (LFSR_SEED),
        .step     (lfsr_step),
        .par_in   ({LFSR_W{1'b0}}),
        .value    (lfsr_value)
    );

    bist_lfsr_misr #(
        .W       (MISR_W),
        .POLY    (MISR_POLY),
        .RST_VAL ({MISR_W{1'b0}})
    ) u_misr (
        .clock    (clock),
        .reset    (reset),
        .load     (run_load),
        .load_val ({MISR_W{1'b0}}),
        .step     (misr_step),
        .par_in   (misr_par_in),
        .value    (misr_value)
    );

    assign signature = misr_value;
    assign pass      = (state_reg == DONE) && (misr_value == GOLDEN_SIG);

endmodule

// File: tb/tb_bist_scan_ctrl.sv
// Testbench for bist_scan_ctrl: a table of whole runs (CUT behaviour,
// abort/reset points, expected busy length) checked cycle by cycle
// against a schedule-based reference model, plus hand-written sequences.
module tb_bist_scan_ctrl;

    localparam int          NC       = 2;
    localparam int          CL       = 8;
    localparam int          NP       = 16;
    localparam int          RUN_LEN  = NP * (CL + 1) + CL;
    localparam logic [15:0] SEED     = 16'hACE1;
    localparam logic [15:0] POLY     = 16'h1021;
    localparam logic [15:0] GOLDEN   = 16'h0000;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [NC-1:0] scan_out;
    logic [NC-1:0] scan_in;
    logic          scan_en;
    logic          busy;
    logic          done;
    logic          pass;
    logic [15:0]   signature;

    int n_checks = 0;
    int n_err    = 0;

    // CUT model: two 8-flop chains, mode 0 = outputs tied low,
    // 1 = good loopback CUT, 2 = same CUT with a flop stuck at 1,
    // 3 = random responses.
    int         cut_mode;
    logic [7:0] chain [NC];

    always #5 clock = ~clock;

    bist_scan_ctrl #(
        .N_CHAINS   (NC),
        .CHAIN_LEN  (CL),
        .N_PATTERNS (NP),
        .LFSR_W     (16),
        .LFSR_POLY  (POLY),
        .LFSR_SEED  (SEED),
        .MISR_W     (16),
        .MISR_POLY  (POLY),
        .GOLDEN_SIG (GOLDEN)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .scan_out  (scan_out),
        .scan_in   (scan_in),
        .scan_en   (scan_en),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .signature (signature)
    );

    typedef struct {
        int mode;
        int abort_at;
        int reset_at;
        bit hold;
        int exp_busy;
        bit exp_done;
    } run_vec_t;

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], 1'b0} ^ (l[15] ? POLY : 16'h0000);
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [NC-1:0] so);
        return {m[14:0], 1'b0} ^ (m[15] ? POLY : 16'h0000) ^ {14'b0, so};
    endfunction

    task automatic chk(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (t=%0d): got 0x%0h, expected 0x%0h", name, t, act, exp);
        end
    endtask

    // Drive this cycle's CUT response and advance the CUT to its
    // post-edge state, reacting to the controller's current outputs.
    task automatic cut_eval();
        logic [7:0] c0;
        logic [7:0] c1;
        c0 = chain[0];
        c1 = chain[1];
        case (cut_mode)
            0:       scan_out = '0;
            3:       scan_out = NC'($urandom);
            default: scan_out = {c1[7], c0[7]};
        endcase
        if (scan_en === 1'b1) begin
            chain[0] = {c0[6:0], scan_in[0]};
            chain[1] = {c1[6:0], scan_in[1]};
        end else begin
            chain[0] = c0 ^ {c1[6:0], c1[7]} ^ 8'h5A;
            chain[1] = ~c1 ^ {1'b0, c0[7:1]};
        end
        if (cut_mode == 2) chain[1][3] = 1'b1;
    endtask

    task automatic cycle();
        @(negedge clock);
        cut_eval();
    endtask

    task automatic chk_idle(input string tag, input int t);
        chk({tag, "_busy"},    t, 32'(busy),    32'd0);
        chk({tag, "_done"},    t, 32'(done),    32'd0);
        chk({tag, "_scan_en"}, t, 32'(scan_en), 32'd0);
        chk({tag, "_scan_in"}, t, 32'(scan_in), 32'd0);
        chk({tag, "_pass"},    t, 32'(pass),    32'd0);
    endtask

    // One run from IDLE/DONE. The expected schedule is derived from the
    // cycle index: 16 rounds of 8 shifts + 1 capture, then 8 unload shifts.
    task automatic do_run(input run_vec_t v, output logic [15:0] dut_sig, output int busy_seen);
        logic [15:0]   lfsr_m;
        logic [15:0]   sig_m;
        int            p;
        int            pos;
        bit            is_shift;
        bit            is_unload;
        bit            compact;
        logic [NC-1:0] exp_si;
        lfsr_m    = SEED;
        sig_m     = '0;
        busy_seen = 0;
        dut_sig   = '0;
        cut_mode  = v.mode;
        start = 1'b1;
        cycle();
        if (!v.hold) start = 1'b0;
        for (int t = 0; t <= RUN_LEN; t++) begin
            if (t == RUN_LEN) begin
                chk("end_done",    t, 32'(done),      32'd1);
                chk("end_busy",    t, 32'(busy),      32'd0);
                chk("end_scan_en", t, 32'(scan_en),   32'd0);
                chk("end_sig",     t, 32'(signature), 32'(sig_m));
                chk("end_pass",    t, 32'(pass),      32'(sig_m == GOLDEN));
                dut_sig = signature;
                break;
            end
            p         = t / (CL + 1);
            pos       = t % (CL + 1);
            is_unload = (t >= NP * (CL + 1));
            is_shift  = !is_unload && (pos < CL);
            compact   = is_unload || (is_shift && p > 0);
            exp_si    = is_shift ? lfsr_m[NC-1:0] : '0;
            if (busy === 1'b1) busy_seen++;
            chk("run_busy",    t, 32'(busy),      32'd1);
            chk("run_done",    t, 32'(done),      32'd0);
            chk("run_scan_en", t, 32'(scan_en),   32'(is_shift || is_unload));
            chk("run_scan_in", t, 32'(scan_in),   32'(exp_si));
            chk("run_sig",     t, 32'(signature), 32'(sig_m));
            if (t == v.abort_at) begin
                abort = 1'b1;
                cycle();
                abort = 1'b0;
                chk_idle("abort", t);
                chk("abort_sig_hold", t, 32'(signature), 32'(sig_m));
                dut_sig = signature;
                break;
            end
            if (t == v.reset_at) begin
                reset = 1'b1;
                cycle();
                chk_idle("reset", t);
                chk("reset_sig", t, 32'(signature), 32'd0);
                reset = 1'b0;
                dut_sig = signature;
                break;
            end
            if (compact)  sig_m  = misr_step(sig_m, scan_out);
            if (is_shift) lfsr_m = lfsr_step(lfsr_m);
            if (v.hold && t == RUN_LEN - 1) start = 1'b0;
            cycle();
        end
    endtask

    initial begin
        run_vec_t    tbl [9];
        logic [15:0] sigs [9];
        int          busy_seen;
        logic [15:0] held_sig;

        //            mode abort reset hold busy done
        tbl[0] = '{0, -1, -1, 1'b0, RUN_LEN, 1'b1};  // zero response
        tbl[1] = '{1, -1, -1, 1'b0, RUN_LEN, 1'b1};  // good CUT
        tbl[2] = '{1, -1, -1, 1'b0, RUN_LEN, 1'b1};  // restart from DONE
        tbl[3] = '{2, -1, -1, 1'b0, RUN_LEN, 1'b1};  // stuck-at fault
        tbl[4] = '{3, -1, -1, 1'b0, RUN_LEN, 1'b1};  // random responses
        tbl[5] = '{1, -1, -1, 1'b1, RUN_LEN, 1'b1};  // start held high
        tbl[6] = '{3, 40, -1, 1'b0, 41,      1'b0};  // abort mid-SHIFT
        tbl[7] = '{3, -1, 70, 1'b0, 71,      1'b0};  // reset mid-run
        tbl[8] = '{0, -1, -1, 1'b0, RUN_LEN, 1'b1};  // fresh run afterwards

        reset    = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        scan_out = '0;
        cut_mode = 0;
        chain[0] = '0;
        chain[1] = '0;
        cycle();
        cycle();
        chk_idle("rst", 0);
        chk("rst_sig", 0, 32'(signature), 32'd0);
        reset = 1'b0;
        cycle();
        chk_idle("idle", 0);

        // abort and start together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        cycle();
        start = 1'b0;
        abort = 1'b0;
        chk_idle("idle_abort_start", 0);
        cycle();
        chk_idle("idle_abort_start_next", 1);

        for (int i = 0; i < 9; i++) begin
            do_run(tbl[i], sigs[i], busy_seen);
            chk($sformatf("busy_len_%0d", i), i, 32'(busy_seen), 32'(tbl[i].exp_busy));
            chk($sformatf("done_end_%0d", i), i, 32'(done), 32'(tbl[i].exp_done));
            $display("run %0d mode=%0d busy_cycles=%0d done=%0d pass=%0d sig=%04h",
                     i, tbl[i].mode, busy_seen, done, pass, sigs[i]);
        end

        chk("restart_same_sig",   2, 32'(sigs[2]), 32'(sigs[1]));
        chk("held_start_same_sig", 5, 32'(sigs[5]), 32'(sigs[1]));
        chk("fault_sig_differs",  3, 32'(sigs[3] != sigs[1]), 32'd1);

        // DONE holds until start/abort
        cycle();
        cycle();
        chk("done_held", 0, 32'(done), 32'd1);
        chk("done_pass", 0, 32'(pass), 32'd1);
        held_sig = signature;

        // abort + start in DONE: abort wins, MISR holds
        start = 1'b1;
        abort = 1'b1;
        cycle();
        start = 1'b0;
        abort = 1'b0;
        chk_idle("done_abort_start", 0);
        chk("done_abort_sig_hold", 0, 32'(signature), 32'(held_sig));
        cycle();
        chk_idle("after_done_abort", 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
